pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Program-counter stage of the single-cycle MIPS core, directly downstream of the left-shift-by-2 stage.
- Consumes the shifted branch offset (sign-extended immediate << 2) and the jump index.
- Holds the architectural PC and computes PC+4, branch, jump and jump-register targets.
- Sequences instruction-memory fetches with a req/ready handshake and a hazard hold.

Parameters:
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset.
- BOOT_CYCLES, 2, idle cycles after reset release before the first fetch request (1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- shifted_offset  input  32  branch offset already shifted left by 2 (from the shift stage).
- jump_index  input  26  instr[25:0] for J/JAL.
- reg_target  input  32  rs value for JR.
- branch_taken  input  1  branch condition met for the current instruction.
- jump  input  1  current instruction is J/JAL.
- jump_reg  input  1  current instruction is JR.
- hold  input  1  hazard stall; freeze the PC.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; always equals pc.
- imem_ready  input  1  instruction returned this cycle.
- pc  output  32  current PC.
- pc_plus4  output  32  pc + 4, the JAL link value.
- instr_done  output  1  one-cycle pulse when an instruction retires and the PC advances.
- misalign_err  output  1  sticky flag: JR target had a nonzero [1:0].
- retire_count  output  32  number of retired instructions.

Behaviour:
Reset (async assert, any state):
- pc = RESET_VECTOR, imem_req = 0, instr_done = 0, misalign_err = 0, retire_count = 0.
- Boot counter = 0; state = BOOT.

State machine:
- BOOT: imem_req = 0. Count BOOT_CYCLES cycles after rst_n deasserts, then go to FETCH.
- FETCH: imem_req = 1, imem_addr = pc.
  - If imem_ready = 1 and hold = 0: retire. pc <= next_pc, instr_done pulses in the same cycle, retire_count += 1 (wraps at 2^32). Stay in FETCH.
  - If imem_ready = 1 and hold = 1: go to STALL. pc is unchanged. The returned instruction is considered still in flight.
- STALL: imem_req = 0, pc frozen. Control inputs are re-sampled on the exit cycle. When hold = 0, retire using the current control inputs and go to FETCH.

Next-PC selection (combinational, evaluated only on the retire cycle):
- Priority order: jump_reg > jump > branch_taken > sequential.
- Sequential: pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Branch: (pc + 4) + shifted_offset, modulo 2^32, two's complement.
- Jump: {pc_plus4[31:28], jump_index, 2'b00}.
- Jump-register: {reg_target[31:2], 2'b00}. If reg_target[1:0] != 0, set misalign_err = 1. The flag stays set until reset.

Other rules:
- pc_plus4 is combinational from pc.
- Control inputs are ignored outside retire cycles.
- Simultaneous jump and branch_taken: jump wins; no error.
- imem_ready seen while in BOOT or STALL is ignored.
- Reset mid-stall or mid-fetch aborts immediately. No retire pulse and no count increment.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding: BOOT = 2'd0, FETCH = 2'd1, STALL = 2'd2.
  - next-PC select constants: NPC_SEQ, NPC_BR, NPC_J, NPC_JR.
  - the default RESET_VECTOR.
- One sub-module, pc_target_mux: purely combinational target computation and priority select. The FSM, PC register and counters live in pc_next_unit.

Test Plan:
- Reset, BOOT_CYCLES = 2 -> imem_req = 0 for 2 cycles after rst_n rises, then 1. imem_addr = 32'h0040_0000. retire_count = 0.
- Sequential flow: imem_ready held 1 for 3 cycles, no control -> pc steps 0x00400000, 0x00400004, 0x00400008, 0x0040000C. instr_done pulses 3 times; retire_count = 3.
- Branch: pc = 0x00400010, shifted_offset = 32'hFFFF_FFF0, branch_taken = 1, ready -> pc = 0x00400004. Then jump = 1 with jump_index = 26'h0000100 -> pc = 0x00000400 (top nibble of 0x00400008 is 0).
- JR misaligned: reg_target = 0x00400023, jump_reg = 1, jump = 1 -> pc = 0x00400020, jump_reg wins. misalign_err = 1 and remains 1 after 5 further sequential retires.
- Hold: hold = 1 with imem_ready = 1 -> STALL, pc unchanged, imem_req = 0 for 4 cycles. Release hold with branch_taken = 1, shifted_offset = 8 -> pc = old pc + 12, one instr_done pulse.
- Wrap and mid-stall reset: pc = 0xFFFFFFFC, retire -> pc = 0. Enter STALL, assert rst_n = 0 asynchronously mid-cycle -> pc = 0x00400000 immediately, misalign_err = 0, no instr_done pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the single-cycle MIPS core front end.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_e;

  // Next-PC source select
  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC target computation with jr > j > branch > seq priority.
module pc_target_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] shifted_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic [1:0]  sel
);

  npc_sel_e sel_e;

  assign pc_plus4 = pc + 32'd4;
  assign sel      = 2'(sel_e);

  // Priority select of the target source
  always_comb begin
    sel_e = NPC_SEQ;
    if (jump_reg)          sel_e = NPC_JR;
    else if (jump)         sel_e = NPC_J;
    else if (branch_taken) sel_e = NPC_BR;
  end

  // Target value for the selected source
  always_comb begin
    next_pc = pc_plus4;
    case (sel_e)
      NPC_BR:  next_pc = pc_plus4 + shifted_offset;
      NPC_J:   next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      NPC_JR:  next_pc = {reg_target[31:2], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// PC register, fetch handshake sequencer and retire bookkeeping.
module pc_next_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] shifted_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_done,
  output logic        misalign_err,
  output logic [31:0] retire_count
);

  localparam int unsigned BOOT_W = 4;

  state_e            state;
  logic [BOOT_W-1:0] boot_cnt;
  logic [31:0]       next_pc;
  logic [1:0]        sel;
  logic              retire;

  pc_target_mux u_mux (
    .pc             (pc),
    .shifted_offset (shifted_offset),
    .jump_index     (jump_index),
    .reg_target     (reg_target),
    .branch_taken   (branch_taken),
    .jump           (jump),
    .jump_reg       (jump_reg),
    .pc_plus4       (pc_plus4),
    .next_pc        (next_pc),
    .sel            (sel)
  );

  assign imem_addr = pc;

  // An instruction retires on a ready fetch without hold, or when a stall releases
  always_comb begin
    retire = 1'b0;
    if (state == FETCH && imem_ready && !hold) retire = 1'b1;
    if (state == STALL && !hold)               retire = 1'b1;
  end

  // Fetch sequencer, PC register and retire counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      boot_cnt     <= '0;
      pc           <= RESET_VECTOR;
      imem_req     <= 1'b0;
      instr_done   <= 1'b0;
      misalign_err <= 1'b0;
      retire_count <= '0;
    end else begin
      instr_done <= 1'b0;
      case (state)
        BOOT: begin
          if (boot_cnt == BOOT_W'(BOOT_CYCLES - 1)) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end else begin
            boot_cnt <= boot_cnt + BOOT_W'(1);
          end
        end
        FETCH: begin
          if (imem_ready && hold) begin
            state    <= STALL;
            imem_req <= 1'b0;
          end
        end
        STALL: begin
          if (!hold) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase

      if (retire) begin
        pc           <= next_pc;
        instr_done   <= 1'b1;
        retire_count <= retire_count + 32'd1;
        if (sel == 2'(NPC_JR) && reg_target[1:0] != 2'b00) misalign_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit with a behavioural fetch/retire model.
module tb_pc_next_unit;

  localparam logic [31:0] RV   = 32'h0040_0000;
  localparam int          BOOT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] shifted_offset = '0;
  logic [25:0] jump_index = '0;
  logic [31:0] reg_target = '0;
  logic        branch_taken = 1'b0, jump = 1'b0, jump_reg = 1'b0, hold = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_req, instr_done, misalign_err;
  logic [31:0] imem_addr, pc, pc_plus4, retire_count;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_count;
  logic        m_done, m_err, m_req;
  int          m_boot;
  bit          m_stall;

  pc_next_unit #(.RESET_VECTOR(RV), .BOOT_CYCLES(BOOT)) dut (
    .clk(clk), .rst_n(rst_n), .shifted_offset(shifted_offset), .jump_index(jump_index),
    .reg_target(reg_target), .branch_taken(branch_taken), .jump(jump), .jump_reg(jump_reg),
    .hold(hold), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .pc(pc), .pc_plus4(pc_plus4), .instr_done(instr_done), .misalign_err(misalign_err),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_target(input logic [31:0] cur);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jump_reg)          return {reg_target[31:2], 2'b00};
    else if (jump)         return {seq[31:28], jump_index, 2'b00};
    else if (branch_taken) return seq + shifted_offset;
    else                   return seq;
  endfunction

  task automatic model_reset();
    m_pc = RV; m_count = 0; m_done = 0; m_err = 0; m_req = 0; m_boot = BOOT; m_stall = 0;
  endtask

  task automatic model_step();
    bit ret;
    ret = 0;
    m_done = 0;
    if (m_boot > 0) m_boot--;
    else if (m_stall) begin
      if (!hold) begin ret = 1; m_stall = 0; end
    end else if (imem_ready) begin
      if (hold) m_stall = 1;
      else ret = 1;
    end
    if (ret) begin
      if (jump_reg && reg_target[1:0] != 2'b00) m_err = 1;
      m_pc = ref_target(m_pc);
      m_done = 1;
      m_count = m_count + 32'd1;
    end
    m_req = (m_boot == 0) && !m_stall;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic clear_ctrl();
    branch_taken = 0; jump = 0; jump_reg = 0; hold = 0;
    shifted_offset = '0; jump_index = '0; reg_target = '0;
  endtask

  task automatic test_reset();
    clear_ctrl(); imem_ready = 0;
    rst_n = 0; model_reset();
    repeat (2) @(negedge clk);
    checks++; if (pc !== RV) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, RV); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", retire_count); end
    checks++; if (misalign_err !== 1'b0 || instr_done !== 1'b0) begin errors++; $display("FAIL reset_flags err=%b done=%b exp=0,0", misalign_err, instr_done); end
    rst_n = 1;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req1 got=%b exp=0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL boot_req2 got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== RV) begin errors++; $display("FAIL boot_addr got=%h exp=%h", imem_addr, RV); end
  endtask

  task automatic test_sequential();
    imem_ready = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (pc !== RV + 32'(4 * k)) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", k, pc, RV + 32'(4 * k)); end
      checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL seq_done%0d got=%b exp=1", k, instr_done); end
    end
    imem_ready = 0;
    tick();
    checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL seq_idle_done got=%b exp=0", instr_done); end
    checks++; if (retire_count !== 32'd3) begin errors++; $display("FAIL seq_count got=%0d exp=3", retire_count); end
    checks++; if (pc_plus4 !== 32'h0040_0010) begin errors++; $display("FAIL seq_plus4 got=%h exp=00400010", pc_plus4); end
  endtask

  task automatic test_branch_jump();
    imem_ready = 1; jump_reg = 1; reg_target = 32'h0040_0010;
    tick();
    checks++; if (pc !== 32'h0040_0010) begin errors++; $display("FAIL jr_setup got=%h exp=00400010", pc); end
    clear_ctrl(); branch_taken = 1; shifted_offset = 32'hFFFF_FFF0;
    tick();
    checks++; if (pc !== 32'h0040_0004) begin errors++; $display("FAIL branch_back got=%h exp=00400004", pc); end
    clear_ctrl(); jump = 1; branch_taken = 1; jump_index = 26'h0000100;
    tick();
    checks++; if (pc !== 32'h0000_0400) begin errors++; $display("FAIL jump_pc got=%h exp=00000400", pc); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL jump_noerr got=%b exp=0", misalign_err); end
    clear_ctrl(); imem_ready = 0;
    tick();
  endtask

  task automatic test_jr_misalign();
    imem_ready = 1; jump_reg = 1; jump = 1; reg_target = 32'h0040_0023;
    tick();
    checks++; if (pc !== 32'h0040_0020) begin errors++; $display("FAIL jr_pc got=%h exp=00400020", pc); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL jr_err got=%b exp=1", misalign_err); end
    clear_ctrl();
    repeat (5) tick();
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL jr_sticky got=%b exp=1", misalign_err); end
    checks++; if (pc !== 32'h0040_0034) begin errors++; $display("FAIL jr_seq_pc got=%h exp=00400034", pc); end
    imem_ready = 0;
    tick();
  endtask

  task automatic test_hold();
    logic [31:0] old;
    old = 32'h0040_0034;
    imem_ready = 1; hold = 1;
    tick();
    checks++; if (pc !== old || imem_req !== 1'b0 || instr_done !== 1'b0) begin
      errors++; $display("FAIL hold_enter pc=%h req=%b done=%b exp=%h,0,0", pc, imem_req, instr_done, old);
    end
    for (int k = 0; k < 3; k++) begin
      imem_ready = k[0]; branch_taken = 1; jump = 1; shifted_offset = 32'h100;
      tick();
      checks++; if (pc !== old || imem_req !== 1'b0 || instr_done !== 1'b0) begin
        errors++; $display("FAIL hold_stay%0d pc=%h req=%b done=%b exp=%h,0,0", k, pc, imem_req, instr_done, old);
      end
    end
    clear_ctrl(); imem_ready = 0; branch_taken = 1; shifted_offset = 32'd8;
    tick();
    checks++; if (pc !== old + 32'd12) begin errors++; $display("FAIL hold_release_pc got=%h exp=%h", pc, old + 32'd12); end
    checks++; if (instr_done !== 1'b1 || imem_req !== 1'b1) begin errors++; $display("FAIL hold_release done=%b req=%b exp=1,1", instr_done, imem_req); end
    clear_ctrl();
    tick();
    checks++; if (instr_done !== 1'b0 || pc !== old + 32'd12) begin errors++; $display("FAIL hold_one_pulse done=%b pc=%h exp=0,%h", instr_done, pc, old + 32'd12); end
    checks++; if (retire_count !== m_count) begin errors++; $display("FAIL hold_count got=%0d exp=%0d", retire_count, m_count); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      imem_ready     = ($urandom_range(9) < 7);
      hold           = ($urandom_range(9) < 3);
      branch_taken   = $urandom_range(1);
      jump           = ($urandom_range(3) == 0);
      jump_reg       = ($urandom_range(7) == 0);
      shifted_offset = {{14{$urandom_range(1) == 1}}, 16'($urandom), 2'b00};
      jump_index     = 26'($urandom);
      reg_target     = $urandom;
      tick();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc, m_pc); end
      checks++; if (imem_req !== m_req || imem_addr !== m_pc) begin errors++; $display("FAIL rnd_req n=%0d req=%b addr=%h exp=%b,%h", n, imem_req, imem_addr, m_req, m_pc); end
      checks++; if (instr_done !== m_done) begin errors++; $display("FAIL rnd_done n=%0d got=%b exp=%b", n, instr_done, m_done); end
      checks++; if (retire_count !== m_count) begin errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, retire_count, m_count); end
      checks++; if (misalign_err !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, misalign_err, m_err); end
      checks++; if (pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4 n=%0d got=%h exp=%h", n, pc_plus4, m_pc + 32'd4); end
    end
    clear_ctrl(); imem_ready = 0;
    tick();
    if (m_stall) tick();
  endtask

  task automatic test_wrap_reset();
    imem_ready = 1; jump_reg = 1; reg_target = 32'hFFFF_FFFF;
    tick();
    checks++; if (pc !== 32'hFFFF_FFFC || misalign_err !== 1'b1) begin errors++; $display("FAIL wrap_setup pc=%h err=%b exp=fffffffc,1", pc, misalign_err); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got=%h exp=0", pc_plus4); end
    clear_ctrl();
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    hold = 1;
    tick();
    checks++; if (imem_req !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL wrap_stall req=%b pc=%h exp=0,0", imem_req, pc); end
    imem_ready = 0;
    @(posedge clk);
    #3 rst_n = 0;
    model_reset();
    #1;
    checks++; if (pc !== RV) begin errors++; $display("FAIL midrst_pc got=%h exp=%h", pc, RV); end
    checks++; if (misalign_err !== 1'b0 || instr_done !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL midrst_flags err=%b done=%b req=%b exp=0,0,0", misalign_err, instr_done, imem_req);
    end
    checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", retire_count); end
    hold = 0;
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++; if (instr_done !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL midrst_boot done=%b req=%b exp=0,0", instr_done, imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || pc !== RV) begin errors++; $display("FAIL midrst_refetch req=%b pc=%h exp=1,%h", imem_req, pc, RV); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_jump();
    test_jr_misalign();
    test_hold();
    test_random();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
